// File: rtl/dcache_wt_param_if.sv
// CPU-side request handshake and line-wide memory bus of the write-through cache.
// master = CPU/memory environment, slave = the cache.
interface dcache_wt_param_if #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 4
);
    logic                             req_valid;
    logic                             req_write;
    logic [ADDR_W-1:0]                req_addr;
    logic [DATA_W-1:0]                req_wdata;
    logic                             req_ready;
    logic [DATA_W-1:0]                req_rdata;
    logic                             req_hit;
    logic                             inval;
    logic                             mem_read;
    logic                             mem_write;
    logic [ADDR_W-1:0]                mem_addr;
    logic [DATA_W-1:0]                mem_wdata;
    logic [WORDS_PER_LINE*DATA_W-1:0] mem_rdata;
    logic                             busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, inval, mem_rdata,
        input  req_ready, req_rdata, req_hit, mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, inval, mem_rdata,
        output req_ready, req_rdata, req_hit, mem_read, mem_write, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dcache_wt_param.sv
// Parametrised direct-mapped write-through, no-write-allocate data cache.
// Define DCACHE_WT_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_wt_param #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINES          = 4,
    parameter int MEM_LATENCY    = 4
) (
    input  logic               clk,
    input  logic               reset,
    dcache_wt_param_if.slave   bus
`ifdef DCACHE_WT_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_DONE} state_t;

    state_t                                          state_q, state_d;
    logic [ADDR_W-1:0]                               addr_q, addr_d;
    logic [DATA_W-1:0]                               wdata_q, wdata_d;
    logic                                            write_q, write_d;
    logic                                            hit_q, hit_d;
    logic [CNT_W-1:0]                                cnt_q, cnt_d;
    logic [DATA_W-1:0]                               rdata_q, rdata_d;
    logic [LINES-1:0]                                valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]                     tag_q, tag_d;
    logic [LINES-1:0][WORDS_PER_LINE-1:0][DATA_W-1:0] data_q, data_d;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             lookup_hit;

    assign off        = addr_q[OFF_W-1:0];
    assign idx        = addr_q[OFF_W +: IDX_W];
    assign tag        = addr_q[ADDR_W-1 -: TAG_W];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        hit_d         = hit_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        data_d        = data_q;
        rdata_d       = rdata_q;
        bus.req_ready = 1'b0;
        bus.req_hit   = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.inval) begin
                    valid_d = '0;
                end else if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    write_d = bus.req_write;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d = lookup_hit;
                if (!write_q && lookup_hit) begin
                    bus.req_ready = 1'b1;
                    bus.req_hit   = 1'b1;
                    rdata_d       = data_q[idx][off];
                    state_d       = S_IDLE;
                end else begin
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    state_d = write_q ? S_WRITE : S_REFILL;
                end
            end
            S_REFILL: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (cnt_q == '0) begin
                    data_d[idx]  = bus.mem_rdata;
                    tag_d[idx]   = tag;
                    valid_d[idx] = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                bus.req_ready = 1'b1;
                rdata_d       = data_q[idx][off];
                state_d       = S_IDLE;
            end
            S_WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (cnt_q == '0) begin
                    // no-write-allocate: only a resident line is updated
                    if (hit_q) data_d[idx][off] = wdata_q;
                    bus.req_ready = 1'b1;
                    bus.req_hit   = hit_q;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load data is shown combinationally on the completion cycle and held afterwards.
    assign bus.req_rdata = (bus.req_ready && !write_q) ? rdata_d : rdata_q;
    assign bus.busy      = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    // Tags and data need no reset; a line is only visible through its valid bit.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef DCACHE_WT_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (bus.req_ready) begin
            if (bus.req_hit) begin
                if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule
